win3x3_linebuf: RTL and testbench
=================================

# win3x3_linebuf

Parametrised 3x3 neighbourhood generator for the Canny pipeline. It replaces fixed 1024-pixel, 13-bit window taps with a configurable-width line-buffered window that knows frame geometry. It handles image borders in zero or replicate mode and self-flushes the last row and column, so each frame yields exactly one centred window per input pixel. It sits between the pixel source (or the previous filter stage) and the Gaussian/Sobel/NMS operators.

## Interface
- DW, 13: pixel width in bits.
- IMG_W, 1024: pixels per row, ≥3.
- IMG_H, 768: rows per frame, ≥3.
- BORDER_MODE, 1: out-of-image taps; 0 = zero, 1 = replicate nearest edge pixel.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din_vld  in  1  input pixel valid; accepted when din_vld & din_rdy.
- din_sof  in  1  marks pixel (0,0); qualified by acceptance.
- din  in  DW  pixel, raster order.
- din_rdy  out  1  low only during FLUSH.
- dout_vld  out  1  one-cycle strobe per window.
- dout_x  out  $clog2(IMG_W)  centre column.
- dout_y  out  $clog2(IMG_H)  centre row.
- a1..a9  out  DW each  window. a1-a3 = row y-1, a4-a6 = row y, a7-a9 = row y+1, each row ordered left to right. a5 is the centre pixel.

## Operation
- Two internal line buffers, each IMG_W deep and DW wide, inferred RAM. They advance only on accepted pixels or flush cycles. A 3x3 raw register window is fed from line buffer 1 (oldest row), line buffer 0, and din.
- Counters: input column and row, input linear index n. Centre index c = n-(IMG_W+1).
- FSM:
  - IDLE: accepted pixel with din_sof → FILL, n=0. Accepted pixels without din_sof are dropped.
  - FILL: no output until n = IMG_W+1 is reached → RUN.
  - RUN: each accepted pixel emits one window for centre c. After the pixel with n = IMG_W*IMG_H-1 is accepted → FLUSH.
  - FLUSH: din_rdy=0. Emits IMG_W+1 windows on consecutive cycles, with fabricated input treated as out-of-image. Then → IDLE.
- Accepted din_sof in FILL or RUN aborts the frame. Pending windows are discarded with no flush. That pixel becomes (0,0) and the FSM enters FILL.
- Border: a tap whose coordinate is outside [0,IMG_W-1]x[0,IMG_H-1] is muxed by centre-position flags (x==0, x==W-1, y==0, y==H-1).
  - BORDER_MODE=0: tap is 0.
  - BORDER_MODE=1: tap takes the clamped-coordinate pixel.
  - Taps never take pixels from an adjacent row or a previous frame.
- Outputs per frame = IMG_W*IMG_H, centres in raster order.

## Timing
- Reset: a1..a9=0, dout_vld=0, dout_x=0, dout_y=0, din_rdy=1, FSM=IDLE, counters=0, line-buffer contents don't-care.
- Latency: the window for centre c is registered and valid 1 clk after the acceptance of input n=c+IMG_W+1, or 1 clk after the corresponding flush cycle.
- din_rdy falls in the cycle after the last pixel is accepted. It stays low for exactly IMG_W+1 cycles and rises in the cycle after the final flush window is generated.
- din_vld gaps in RUN/FILL stall the pipeline. Outputs are unchanged in value and order; dout_vld stays 0 during gaps.
- Back-to-back frames: the next din_sof may be accepted the first cycle din_rdy=1.
- Reset mid-operation: all state returns immediately to reset values and the frame is lost.
- Counter wrap: column wraps to 0 at IMG_W-1 and row increments. n is compared against IMG_W*IMG_H-1 and never overflows.

## Test plan
- Bench setup for all cases: IMG_W=4, IMG_H=3, DW=8, pixel = 16*y+x, continuous din_vld.
- Mode 1: centre (0,0) → a1..a9 = 0,0,1,0,0,1,16,16,17. Centre (1,1) → 0,1,2,16,17,18,32,33,34. Centre (3,2) → 18,19,19,34,35,35,34,35,35.
- Mode 0: centre (0,0) → 0,0,0,0,0,1,0,16,17. Centre (3,2) → 18,19,0,34,35,0,0,0,0.
- Count/latency: 12 pixels in → exactly 12 dout_vld. The first arrives 1 clk after the 6th acceptance (n=5). din_rdy is low for exactly 5 cycles. dout_x/dout_y run raster 0..3 / 0..2.
- Random din_vld gaps (50%) → window values and order identical to the continuous case.
- din_sof on the 8th pixel → no flush, no stale windows. The new frame's 12 windows match the mode-1 expectations.
- rst_n low for 1 clk mid-RUN → all outputs 0 immediately. A following full frame produces 12 correct windows.

Source files
------------

// File: rtl/win3x3_linebuf.sv
// win3x3_linebuf: line-buffered 3x3 window generator with zero/replicate borders
// and an end-of-frame flush so every input pixel yields one centred window.
module win3x3_linebuf #(
    parameter int DW          = 13,
    parameter int IMG_W       = 1024,
    parameter int IMG_H       = 768,
    parameter bit BORDER_MODE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din_vld,
    input  logic                     din_sof,
    input  logic [DW-1:0]            din,
    output logic                     din_rdy,
    output logic                     dout_vld,
    output logic [$clog2(IMG_W)-1:0] dout_x,
    output logic [$clog2(IMG_H)-1:0] dout_y,
    output logic [DW-1:0]            a1,
    output logic [DW-1:0]            a2,
    output logic [DW-1:0]            a3,
    output logic [DW-1:0]            a4,
    output logic [DW-1:0]            a5,
    output logic [DW-1:0]            a6,
    output logic [DW-1:0]            a7,
    output logic [DW-1:0]            a8,
    output logic [DW-1:0]            a9
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int NW = $clog2(IMG_W*IMG_H+IMG_W+1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t        st_q, st_d;
    logic [NW-1:0] n_q, n_e;
    logic [XW-1:0] col_q, col_e, cx_q, x_q;
    logic [YW-1:0] cy_q, y_q;
    logic          rdy_q, vld_q, acc, sof, step, emit, flush;
    logic          top, bot, lft, rgt;
    logic [DW-1:0] pix;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] w_q [3][3];
    logic [DW-1:0] w_d [3][3];
    logic [DW-1:0] tap [3][3];
    logic [DW-1:0] a_q [3][3];

    // An accepted sof restarts the frame at index 0 regardless of current state.
    always_comb begin
        flush = st_q == FLUSH;
        acc   = din_vld & rdy_q;
        sof   = acc & din_sof;
        step  = flush | sof | (acc & (st_q != IDLE));
        n_e   = sof ? '0 : n_q;
        col_e = sof ? '0 : col_q;
        emit  = step & (n_e > NW'(IMG_W));
        pix   = flush ? '0 : din;
        top   = cy_q == '0;
        bot   = cy_q == YW'(IMG_H-1);
        lft   = cx_q == '0;
        rgt   = cx_q == XW'(IMG_W-1);
        st_d  = sof ? FILL
              : (st_q == FILL && step && n_q == NW'(IMG_W+1)) ? RUN
              : (st_q == RUN && step && n_q == NW'(IMG_W*IMG_H-1)) ? FLUSH
              : (flush && n_q == NW'(IMG_W*IMG_H+IMG_W)) ? IDLE : st_q;
    end

    // Raw window columns hold x-1, x, x+1; rows hold y-1, y, y+1 of the next centre.
    for (genvar r = 0; r < 3; r++) begin : g_r
        assign w_d[r][0] = w_q[r][1];
        assign w_d[r][1] = w_q[r][2];
        assign w_d[r][2] = (r == 0) ? lb1[col_e] : (r == 1) ? lb0[col_e] : pix;
        for (genvar k = 0; k < 3; k++) begin : g_k
            logic cr, ck;
            assign cr = (r == 0) ? top : (r == 2) ? bot : 1'b0;
            assign ck = (k == 0) ? lft : (k == 2) ? rgt : 1'b0;
            assign tap[r][k] = BORDER_MODE ? w_d[cr ? 2'd1 : 2'(r)][ck ? 2'd1 : 2'(k)]
                                           : (cr | ck) ? '0 : w_d[r][k];
        end
    end

    always_ff @(posedge clk) begin
        if (step) begin
            lb0[col_e] <= pix;
            lb1[col_e] <= lb0[col_e];
            w_q        <= w_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            n_q   <= '0;
            col_q <= '0;
            cx_q  <= '0;
            cy_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
            a_q   <= '{default: '0};
        end else begin
            st_q  <= st_d;
            rdy_q <= st_d != FLUSH;
            vld_q <= emit;
            n_q   <= (st_d == IDLE) ? '0 : step ? n_e + 1'b1 : n_q;
            col_q <= (st_d == IDLE) ? '0 : step ? ((col_e == XW'(IMG_W-1)) ? '0 : col_e + 1'b1) : col_q;
            if (sof) begin
                cx_q <= '0;
                cy_q <= '0;
            end
            if (emit) begin
                x_q  <= cx_q;
                y_q  <= cy_q;
                cx_q <= rgt ? '0 : cx_q + 1'b1;
                cy_q <= rgt ? (bot ? '0 : cy_q + 1'b1) : cy_q;
                a_q  <= tap;
            end
        end
    end

    assign din_rdy  = rdy_q;
    assign dout_vld = vld_q;
    assign dout_x   = x_q;
    assign dout_y   = y_q;
    assign a1 = a_q[0][0];
    assign a2 = a_q[0][1];
    assign a3 = a_q[0][2];
    assign a4 = a_q[1][0];
    assign a5 = a_q[1][1];
    assign a6 = a_q[1][2];
    assign a7 = a_q[2][0];
    assign a8 = a_q[2][1];
    assign a9 = a_q[2][2];
endmodule

// File: tb/tb_win3x3_linebuf.sv
// tb_win3x3_linebuf: directed checks of both border modes on a 4x3 frame
// with pixel = 16*y+x, covering gaps, frame abort and mid-frame reset.
module tb_win3x3_linebuf;
    logic       clk = 0, rst_n = 0, vld = 0, sof = 0;
    logic [7:0] din = 0;
    logic       rdy [2];
    logic       ov  [2];
    logic [1:0] ox  [2];
    logic [1:0] oy  [2];
    logic [7:0] w   [2][9];
    int errs = 0, checks = 0, acc_cnt = 0, rdy_low = 0;
    int got [2];
    int first [2];
    logic [7:0] h1 [3][9] = '{'{0, 0, 1, 0, 0, 1, 16, 16, 17},
                              '{0, 1, 2, 16, 17, 18, 32, 33, 34},
                              '{18, 19, 19, 34, 35, 35, 34, 35, 35}};
    logic [7:0] h0 [2][9] = '{'{0, 0, 0, 0, 0, 1, 0, 16, 17},
                              '{18, 19, 0, 34, 35, 0, 0, 0, 0}};

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        win3x3_linebuf #(.DW(8), .IMG_W(4), .IMG_H(3), .BORDER_MODE(m == 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .din_vld(vld), .din_sof(sof), .din(din),
            .din_rdy(rdy[m]), .dout_vld(ov[m]), .dout_x(ox[m]), .dout_y(oy[m]),
            .a1(w[m][0]), .a2(w[m][1]), .a3(w[m][2]), .a4(w[m][3]), .a5(w[m][4]),
            .a6(w[m][5]), .a7(w[m][6]), .a8(w[m][7]), .a9(w[m][8])
        );
    end

    function automatic logic [7:0] model(input bit mode, input int x, input int y, input int t);
        int xx, yy;
        xx = x + t % 3 - 1;
        yy = y + t / 3 - 1;
        if (xx < 0 || xx > 3 || yy < 0 || yy > 2) begin
            if (!mode) return 8'd0;
            xx = xx < 0 ? 0 : xx > 3 ? 3 : xx;
            yy = yy < 0 ? 0 : yy > 2 ? 2 : yy;
        end
        return 8'(16 * yy + xx);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int ex, ey, hi;
        @(posedge clk);
        #1;
        if (!rdy[1]) rdy_low++;
        for (int m = 0; m < 2; m++) begin
            if (ov[m]) begin
                ex = got[m] % 4;
                ey = got[m] / 4;
                hi = got[m] == 0 ? 0 : got[m] == 5 ? 1 : got[m] == 11 ? 2 : -1;
                chk($sformatf("m%0d window %0d within frame", m, got[m]), got[m] < 12, 1);
                chk($sformatf("m%0d win%0d dout_x", m, got[m]), ox[m], ex);
                chk($sformatf("m%0d win%0d dout_y", m, got[m]), oy[m], ey);
                for (int t = 0; t < 9; t++) begin
                    chk($sformatf("m%0d (%0d,%0d) a%0d", m, ex, ey, t + 1), w[m][t], model(m == 1, ex, ey, t));
                    if (m == 1 && hi >= 0)
                        chk($sformatf("hand m1 (%0d,%0d) a%0d", ex, ey, t + 1), w[m][t], h1[hi][t]);
                    if (m == 0 && (hi == 0 || hi == 2))
                        chk($sformatf("hand m0 (%0d,%0d) a%0d", ex, ey, t + 1), w[m][t], h0[hi / 2][t]);
                end
                got[m]++;
                if (got[m] == 1) first[m] = acc_cnt;
            end
        end
    endtask

    task automatic drive(input int n, input int gap);
        int i;
        logic a;
        i = 0;
        for (int c = 0; c < 1000 && i < n; c++) begin
            vld = $urandom_range(99) >= gap;
            sof = i == 0;
            din = 8'(16 * (i / 4) + i % 4);
            a = vld & rdy[1];
            if (a) acc_cnt++;
            tick();
            if (a) i++;
        end
        vld = 0;
        sof = 0;
        chk("pixels accepted", i, n);
    endtask

    task automatic frame(input int gap);
        got = '{0, 0};
        first = '{0, 0};
        acc_cnt = 0;
        drive(12, gap);
        for (int k = 0; k < 40 && got[1] < 12; k++) tick();
        repeat (4) tick();
        chk("m1 window count", got[1], 12);
        chk("m0 window count", got[0], 12);
        chk("m1 first window after acceptance", first[1], 6);
        chk("m0 first window after acceptance", first[0], 6);
        chk("din_rdy low cycles", rdy_low, 5);
    endtask

    task automatic chk_reset(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s m%0d dout_vld", tag, m), ov[m], 0);
            chk($sformatf("%s m%0d dout_x", tag, m), ox[m], 0);
            chk($sformatf("%s m%0d dout_y", tag, m), oy[m], 0);
            chk($sformatf("%s m%0d din_rdy", tag, m), rdy[m], 1);
            for (int t = 0; t < 9; t++) chk($sformatf("%s m%0d a%0d", tag, m, t + 1), w[m][t], 0);
        end
    endtask

    initial begin
        got = '{0, 0};
        first = '{0, 0};
        repeat (2) tick();
        chk_reset("reset");
        rst_n = 1;
        rdy_low = 0;
        frame(0);
        rdy_low = 0;
        frame(50);
        got = '{0, 0};
        acc_cnt = 0;
        rdy_low = 0;
        drive(7, 0);
        chk("aborted frame windows", got[1], 2);
        frame(0);
        got = '{0, 0};
        acc_cnt = 0;
        drive(8, 0);
        chk("pre-reset windows", got[1], 3);
        rst_n = 0;
        #1;
        chk_reset("midrun reset");
        tick();
        rst_n = 1;
        rdy_low = 0;
        frame(0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
